// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the reaction-timer game: lights, random delay, timing, result.
// Optional best-time tracking is enabled by defining REACTION_BEST_EN.
//
// state       | meaning
// IDLE        | waiting for start after reset
// LIGHTS      | lighting LEDs one per tick_hs, LFSR running
// DELAY       | all lights on, random delay running, LFSR frozen
// TIMING      | lights off, millisecond counter enabled
// RESULT      | reaction time or timeout held for display
// FALSE_START | react seen before lights out, LEDs flashing
module reaction_round_ctrl #(
  parameter int NUM_LIGHTS = 10,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT_MS = 9999
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tick_ms,
  input  logic             tick_hs,
  input  logic             start,
  input  logic             react,
  input  logic             delay_done,
  input  logic [CNT_W-1:0] count_in,
  output logic [9:0]       led,
  output logic             lfsr_en,
  output logic             delay_start,
  output logic             cnt_clear,
  output logic             cnt_en,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             jump_start,
  output logic             timeout,
  output logic [CNT_W-1:0] best
);

  typedef enum logic [2:0] {
    IDLE, LIGHTS, DELAY, TIMING, RESULT, FALSE_START
  } state_t;

  localparam logic [3:0]       LAST_IDX    = 4'(NUM_LIGHTS);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_MS);

  state_t     state;
  logic [3:0] idx;

  // The millisecond counter consumes tick_ms directly; the sequencer only watches count_in.
  logic unused_tick_ms;
  assign unused_tick_ms = tick_ms;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      led          <= '0;
      lfsr_en      <= 1'b1;
      delay_start  <= 1'b0;
      cnt_clear    <= 1'b0;
      cnt_en       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      jump_start   <= 1'b0;
      timeout      <= 1'b0;
`ifdef REACTION_BEST_EN
      best         <= '1;
`endif
    end else begin
      delay_start <= 1'b0;
      cnt_clear   <= 1'b0;
      case (state)
        IDLE, RESULT, FALSE_START: begin
          lfsr_en <= 1'b1;
          if (start) begin
            state        <= LIGHTS;
            led          <= '0;
            idx          <= '0;
            cnt_clear    <= 1'b1;
            cnt_en       <= 1'b0;
            result_valid <= 1'b0;
            jump_start   <= 1'b0;
            timeout      <= 1'b0;
          end else if (state == FALSE_START && tick_hs) begin
            led <= ~led;
          end
        end
        LIGHTS: begin
          // A jump start outranks the light step in the same cycle.
          if (react) begin
            state      <= FALSE_START;
            jump_start <= 1'b1;
            led        <= 10'h2AA;
            cnt_en     <= 1'b0;
            lfsr_en    <= 1'b1;
          end else if (tick_hs) begin
            led <= {1'b1, led[9:1]};
            idx <= idx + 4'd1;
            if (idx + 4'd1 == LAST_IDX) begin
              state       <= DELAY;
              delay_start <= 1'b1;
              lfsr_en     <= 1'b0;
            end
          end
        end
        DELAY: begin
          if (react) begin
            state      <= FALSE_START;
            jump_start <= 1'b1;
            led        <= 10'h2AA;
            cnt_en     <= 1'b0;
            lfsr_en    <= 1'b1;
          end else if (delay_done) begin
            state  <= TIMING;
            led    <= '0;
            cnt_en <= 1'b1;
          end
        end
        TIMING: begin
          if (react) begin
            state        <= RESULT;
            result       <= count_in;
            result_valid <= 1'b1;
            timeout      <= 1'b0;
            cnt_en       <= 1'b0;
            lfsr_en      <= 1'b1;
`ifdef REACTION_BEST_EN
            if (count_in < best) best <= count_in;
`endif
          end else if (count_in >= TIMEOUT_VAL) begin
            state        <= RESULT;
            result       <= TIMEOUT_VAL;
            result_valid <= 1'b0;
            timeout      <= 1'b1;
            cnt_en       <= 1'b0;
            lfsr_en      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef REACTION_BEST_EN
  assign best = '1;
`endif

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed testbench for reaction_round_ctrl with hand-computed expected values.
module tb_reaction_round_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b0;
  logic        tick_ms = 1'b0, tick_hs = 1'b0, start = 1'b0, react = 1'b0, delay_done = 1'b0;
  logic [15:0] count_in = '0;
  logic [9:0]  led;
  logic        lfsr_en, delay_start, cnt_clear, cnt_en, result_valid, jump_start, timeout;
  logic [15:0] result, best;

  int vectors = 0;
  int errors  = 0;

  reaction_round_ctrl dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick_ms(tick_ms), .tick_hs(tick_hs),
    .start(start), .react(react), .delay_done(delay_done), .count_in(count_in),
    .led(led), .lfsr_en(lfsr_en), .delay_start(delay_start), .cnt_clear(cnt_clear),
    .cnt_en(cnt_en), .result(result), .result_valid(result_valid),
    .jump_start(jump_start), .timeout(timeout), .best(best)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  task automatic run_lights();
    count_in = '0;
    start = 1'b1; cyc(); start = 1'b0; cyc();
    for (int i = 0; i < 10; i++) begin
      tick_hs = 1'b1; cyc(); tick_hs = 1'b0; cyc();
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (led !== 10'h000) begin errors++; $display("FAIL rst_led got=%h exp=%h", led, 10'h000); end
    vectors++; if (lfsr_en !== 1'b1) begin errors++; $display("FAIL rst_lfsr_en got=%b exp=1", lfsr_en); end
    vectors++; if (delay_start !== 1'b0) begin errors++; $display("FAIL rst_delay_start got=%b exp=0", delay_start); end
    vectors++; if (cnt_clear !== 1'b0) begin errors++; $display("FAIL rst_cnt_clear got=%b exp=0", cnt_clear); end
    vectors++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL rst_cnt_en got=%b exp=0", cnt_en); end
    vectors++; if (result !== 16'h0000) begin errors++; $display("FAIL rst_result got=%h exp=0000", result); end
    vectors++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_result_valid got=%b exp=0", result_valid); end
    vectors++; if (jump_start !== 1'b0) begin errors++; $display("FAIL rst_jump_start got=%b exp=0", jump_start); end
    vectors++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
    vectors++; if (best !== 16'hFFFF) begin errors++; $display("FAIL rst_best got=%h exp=FFFF", best); end
  endtask

  task automatic test_lights();
    logic [9:0] walk [10];
    walk = '{10'h200, 10'h300, 10'h380, 10'h3C0, 10'h3E0, 10'h3F0, 10'h3F8, 10'h3FC, 10'h3FE, 10'h3FF};
    start = 1'b1; cyc(); start = 1'b0;
    vectors++; if (cnt_clear !== 1'b1) begin errors++; $display("FAIL lt_cnt_clear got=%b exp=1", cnt_clear); end
    vectors++; if (led !== 10'h000) begin errors++; $display("FAIL lt_led0 got=%h exp=000", led); end
    cyc();
    vectors++; if (cnt_clear !== 1'b0) begin errors++; $display("FAIL lt_cnt_clear_drop got=%b exp=0", cnt_clear); end
    for (int i = 0; i < 10; i++) begin
      tick_hs = 1'b1; cyc(); tick_hs = 1'b0;
      vectors++; if (led !== walk[i]) begin errors++; $display("FAIL lt_led[%0d] got=%h exp=%h", i, led, walk[i]); end
      vectors++; if (delay_start !== (i == 9)) begin errors++; $display("FAIL lt_delay_start[%0d] got=%b exp=%b", i, delay_start, i == 9); end
      vectors++; if (lfsr_en !== (i != 9)) begin errors++; $display("FAIL lt_lfsr_en[%0d] got=%b exp=%b", i, lfsr_en, i != 9); end
      cyc();
      vectors++; if (delay_start !== 1'b0) begin errors++; $display("FAIL lt_delay_start_idle[%0d] got=%b exp=0", i, delay_start); end
    end
    vectors++; if (led !== 10'h3FF) begin errors++; $display("FAIL lt_delay_led got=%h exp=3FF", led); end
    vectors++; if (lfsr_en !== 1'b0) begin errors++; $display("FAIL lt_delay_lfsr got=%b exp=0", lfsr_en); end
  endtask

  task automatic test_reaction();
    run_lights();
    delay_done = 1'b1; cyc(); delay_done = 1'b0;
    vectors++; if (led !== 10'h000) begin errors++; $display("FAIL rx_led got=%h exp=000", led); end
    vectors++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL rx_cnt_en got=%b exp=1", cnt_en); end
    start = 1'b1; cyc(); start = 1'b0;
    vectors++; if (cnt_en !== 1'b1 || cnt_clear !== 1'b0) begin errors++; $display("FAIL rx_start_ignored got cnt_en=%b cnt_clear=%b exp 1,0", cnt_en, cnt_clear); end
    count_in = 16'd237; react = 1'b1; cyc(); react = 1'b0;
    vectors++; if (result !== 16'd237) begin errors++; $display("FAIL rx_result got=%0d exp=237", result); end
    vectors++; if (result_valid !== 1'b1) begin errors++; $display("FAIL rx_valid got=%b exp=1", result_valid); end
    vectors++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL rx_cnt_en_off got=%b exp=0", cnt_en); end
    vectors++; if (jump_start !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rx_flags got js=%b to=%b exp 0,0", jump_start, timeout); end
    vectors++; if (lfsr_en !== 1'b1) begin errors++; $display("FAIL rx_lfsr got=%b exp=1", lfsr_en); end
    count_in = 16'd500; react = 1'b1; cyc(); react = 1'b0;
    vectors++; if (result !== 16'd237) begin errors++; $display("FAIL rx_react_ignored got=%0d exp=237", result); end
  endtask

  task automatic test_jump_start();
    count_in = '0;
    start = 1'b1; cyc(); start = 1'b0; cyc();
    for (int i = 0; i < 4; i++) begin
      tick_hs = 1'b1; cyc(); tick_hs = 1'b0; cyc();
    end
    vectors++; if (led !== 10'h3C0) begin errors++; $display("FAIL js_led4 got=%h exp=3C0", led); end
    react = 1'b1; cyc(); react = 1'b0;
    vectors++; if (jump_start !== 1'b1) begin errors++; $display("FAIL js_flag got=%b exp=1", jump_start); end
    vectors++; if (led !== 10'h2AA) begin errors++; $display("FAIL js_led_a got=%h exp=2AA", led); end
    vectors++; if (cnt_en !== 1'b0 || lfsr_en !== 1'b1) begin errors++; $display("FAIL js_en got cnt_en=%b lfsr=%b exp 0,1", cnt_en, lfsr_en); end
    tick_hs = 1'b1; cyc(); tick_hs = 1'b0;
    vectors++; if (led !== 10'h155) begin errors++; $display("FAIL js_led_b got=%h exp=155", led); end
    delay_done = 1'b1; react = 1'b1; cyc(); delay_done = 1'b0; react = 1'b0;
    vectors++; if (led !== 10'h155 || cnt_en !== 1'b0) begin errors++; $display("FAIL js_ignored got led=%h cnt_en=%b exp 155,0", led, cnt_en); end
    tick_hs = 1'b1; cyc(); tick_hs = 1'b0;
    vectors++; if (led !== 10'h2AA) begin errors++; $display("FAIL js_led_c got=%h exp=2AA", led); end
    start = 1'b1; cyc(); start = 1'b0;
    vectors++; if (jump_start !== 1'b0 || cnt_clear !== 1'b1 || led !== 10'h000) begin errors++; $display("FAIL js_restart got js=%b clr=%b led=%h exp 0,1,000", jump_start, cnt_clear, led); end
    cyc();
    // react together with tick_hs in LIGHTS: jump start, no advance
    tick_hs = 1'b1; cyc(); tick_hs = 1'b0;
    tick_hs = 1'b1; react = 1'b1; cyc(); tick_hs = 1'b0; react = 1'b0;
    vectors++; if (jump_start !== 1'b1 || led !== 10'h2AA) begin errors++; $display("FAIL js_tick_prio got js=%b led=%h exp 1,2AA", jump_start, led); end
    // react together with delay_done in DELAY
    run_lights();
    react = 1'b1; delay_done = 1'b1; cyc(); react = 1'b0; delay_done = 1'b0;
    vectors++; if (jump_start !== 1'b1 || cnt_en !== 1'b0 || led !== 10'h2AA) begin errors++; $display("FAIL js_delay_prio got js=%b cnt_en=%b led=%h exp 1,0,2AA", jump_start, cnt_en, led); end
  endtask

  task automatic test_timeout();
    run_lights();
    delay_done = 1'b1; cyc(); delay_done = 1'b0;
    count_in = 16'd9998; cyc();
    vectors++; if (timeout !== 1'b0 || cnt_en !== 1'b1) begin errors++; $display("FAIL to_early got to=%b cnt_en=%b exp 0,1", timeout, cnt_en); end
    count_in = 16'd9999; cyc();
    vectors++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag got=%b exp=1", timeout); end
    vectors++; if (result !== 16'd9999) begin errors++; $display("FAIL to_result got=%0d exp=9999", result); end
    vectors++; if (result_valid !== 1'b0 || cnt_en !== 1'b0) begin errors++; $display("FAIL to_valid got v=%b cnt_en=%b exp 0,0", result_valid, cnt_en); end
    run_lights();
    vectors++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_cleared got=%b exp=0", timeout); end
    delay_done = 1'b1; cyc(); delay_done = 1'b0;
    count_in = 16'd9999; react = 1'b1; cyc(); react = 1'b0;
    vectors++; if (result !== 16'd9999 || timeout !== 1'b0 || result_valid !== 1'b1) begin errors++; $display("FAIL to_react_prio got res=%0d to=%b v=%b exp 9999,0,1", result, timeout, result_valid); end
  endtask

  task automatic best_round(input logic [15:0] ms);
    run_lights();
    delay_done = 1'b1; cyc(); delay_done = 1'b0;
    count_in = ms; react = 1'b1; cyc(); react = 1'b0;
  endtask

  task automatic test_best();
    do_reset();
`ifdef REACTION_BEST_EN
    best_round(16'd300);
    vectors++; if (best !== 16'd300) begin errors++; $display("FAIL best_300 got=%0d exp=300", best); end
    best_round(16'd180);
    vectors++; if (best !== 16'd180) begin errors++; $display("FAIL best_180 got=%0d exp=180", best); end
    best_round(16'd250);
    vectors++; if (best !== 16'd180) begin errors++; $display("FAIL best_250 got=%0d exp=180", best); end
    count_in = 16'd50;
    start = 1'b1; cyc(); start = 1'b0;
    react = 1'b1; cyc(); react = 1'b0;
    vectors++; if (best !== 16'd180 || jump_start !== 1'b1) begin errors++; $display("FAIL best_js got best=%0d js=%b exp 180,1", best, jump_start); end
    do_reset();
    vectors++; if (best !== 16'hFFFF) begin errors++; $display("FAIL best_reset got=%h exp=FFFF", best); end
`else
    best_round(16'd300);
    vectors++; if (best !== 16'hFFFF) begin errors++; $display("FAIL best_tied got=%h exp=FFFF", best); end
    vectors++; if (result !== 16'd300) begin errors++; $display("FAIL best_round_res got=%0d exp=300", result); end
`endif
  endtask

  task automatic test_reset_mid_delay();
    run_lights();
    vectors++; if (led !== 10'h3FF) begin errors++; $display("FAIL rd_in_delay got=%h exp=3FF", led); end
    reset = 1'b1; cyc(); reset = 1'b0;
    vectors++; if (led !== 10'h000 || cnt_en !== 1'b0 || lfsr_en !== 1'b1) begin errors++; $display("FAIL rd_reset got led=%h cnt_en=%b lfsr=%b exp 000,0,1", led, cnt_en, lfsr_en); end
    delay_done = 1'b1; cyc(); delay_done = 1'b0;
    cyc();
    vectors++; if (cnt_en !== 1'b0 || led !== 10'h000) begin errors++; $display("FAIL rd_dd_ignored got cnt_en=%b led=%h exp 0,000", cnt_en, led); end
  endtask

  initial begin
    cyc();
    test_reset();
    test_lights();
    test_reaction();
    test_jump_start();
    test_timeout();
    test_best();
    test_reset_mid_delay();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/reaction_round_ctrl.md
Name: reaction_round_ctrl

Overview:
Round sequencer for the reaction-timer game. It steps the lights pattern on the half-second tick and gates the LFSR. It launches the random delay and enables/clears the millisecond counter. It detects jump starts, captures the reaction time and holds the result for the BCD/7-seg display path. It sits between the tick generators, the debounced KEY pulses and the LFSR/delay/counter datapath, replacing direct FSM-to-datapath wiring in the top level.

Parameters:
NUM_LIGHTS, 10, number of LEDs lit in sequence (1..10)
CNT_W, 16, width of reaction count and result
TIMEOUT_MS, 9999, count value that ends a round with no reaction

Ports:
CLOCK_50  input  1  system clock
reset  input  1  synchronous, active-high reset
tick_ms  input  1  1-cycle strobe every 1 ms
tick_hs  input  1  1-cycle strobe every 0.5 s
start  input  1  1-cycle pulse, debounced start key
react  input  1  1-cycle pulse, debounced reaction key
delay_done  input  1  1-cycle pulse from random delay block
count_in  input  CNT_W  current millisecond counter value
led  output  10  lights pattern to LEDR
lfsr_en  output  1  LFSR advance enable
delay_start  output  1  1-cycle pulse, loads/starts delay
cnt_clear  output  1  1-cycle pulse, clears counter
cnt_en  output  1  counter enable (counter advances on tick_ms)
result  output  CNT_W  captured reaction time, ms
result_valid  output  1  result holds a valid measurement
jump_start  output  1  round aborted by early react
timeout  output  1  round ended at TIMEOUT_MS
best  output  CNT_W  best time since reset (see Optional Feature)

Behaviour:
- All outputs registered. Reset: state IDLE, led=0, lfsr_en=1, delay_start=0, cnt_clear=0, cnt_en=0, result=0, result_valid=0, jump_start=0, timeout=0, best=all ones.
- States: IDLE, LIGHTS, DELAY, TIMING, RESULT, FALSE_START.
- IDLE/RESULT/FALSE_START + start -> LIGHTS.
  - On entry: led=0, light index=0, cnt_clear=1 for one cycle, result_valid, jump_start and timeout cleared.
- LIGHTS: lfsr_en=1.
  - Each tick_hs: led = {1, led[9:1]}, index+1.
  - On the tick that makes index==NUM_LIGHTS: -> DELAY, delay_start=1 for exactly one cycle, lfsr_en=0 (freezes N).
- DELAY: led holds all lit; lfsr_en=0.
  - delay_done -> TIMING: led=0, cnt_en=1 from next cycle.
- TIMING: cnt_en=1.
  - react -> RESULT: result<=count_in, result_valid=1, cnt_en=0.
  - count_in>=TIMEOUT_MS -> RESULT: result=TIMEOUT_MS, timeout=1, result_valid=0.
- react in LIGHTS or DELAY -> FALSE_START: jump_start=1, cnt_en=0.
  - led toggles between 10'h2AA and 10'h155 on each tick_hs, starting 10'h2AA on entry.
- RESULT: led=0, outputs held until start. lfsr_en=1 in IDLE/RESULT/FALSE_START.
- Priorities:
  - DELAY: react + delay_done same cycle -> FALSE_START.
  - TIMING: react + timeout same cycle -> react wins, result=count_in, timeout=0.
  - LIGHTS: react + tick_hs same cycle -> FALSE_START, led not advanced.
- start ignored in LIGHTS, DELAY, TIMING. delay_done ignored outside DELAY. react ignored in IDLE/RESULT/FALSE_START.
- reset asserted in any state: back to reset values next edge, including best.

Optional Feature:
- Macro: REACTION_BEST_EN.
- Defined: on each valid react capture, if count_in<best then best<=count_in in the same cycle result is written. Jump starts and timeouts never update best.
- Undefined: best tied to all ones; no compare logic.

Test Plan:
- reset, start, 10 tick_hs -> led walks 10'h200,10'h300…10'h3FF; delay_start single pulse on 10th tick; lfsr_en falls same cycle.
- Full lights, delay_done, counter driven to 237, react -> state RESULT, result=237, result_valid=1, cnt_en=0, jump_start=0.
- react after 4th tick_hs (led=10'h3C0) -> jump_start=1, led 10'h2AA then 10'h155 on next tick_hs; later start -> LIGHTS, jump_start=0, cnt_clear pulse.
- TIMING with count_in ramped to 9999, no react -> timeout=1, result=9999, result_valid=0; react and count_in=9999 same cycle -> result=9999, timeout=0, result_valid=1.
- REACTION_BEST_EN: rounds of 300, 180, 250 ms -> best 300, 180, 180; jump-start round -> best stays 180; reset -> best=16'hFFFF.
- reset asserted mid-DELAY -> next cycle IDLE, led=0, cnt_en=0, delay_done pulse afterwards ignored.
